key_sched_ctrl: RTL and testbench

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/key_sched_ctrl.sv | 111 +++++++++++
 tb/tb_key_sched_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// AES-128 key schedule sequencer: drives an external one-round expander
// and keeps all 11 round keys for random-access reads.
module key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic [0:127] exp_temp_key,
  output logic [0:31]  exp_rcon,
  input  logic [0:127] exp_key,
  output logic         busy,
  output logic         key_valid,
  input  logic [3:0]   rd_round,
  output logic [0:127] rd_key,
  output logic         rd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic [0:127] r_temp;
  logic [0:127] r_slot [0:10];
  logic         w_accept;
  logic         w_wait;
  logic         w_last;

  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_wait   = (r_state == S_WAIT);
  assign w_last   = (r_round == 4'd10);
  assign w_accept = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    exp_rcon = '0;
    unique case (r_state)
      S_IDLE,
      S_DONE:  if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        w_next   = S_WAIT;
        exp_rcon = {r_rcon, 24'h0};
      end
      S_WAIT: begin
        w_next   = w_last ? S_DONE : S_ISSUE;
        exp_rcon = {r_rcon, 24'h0};
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign exp_temp_key = r_temp;

  // Expander result lands in the slot of the round being closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_round   <= '0;
      r_rcon    <= '0;
      r_temp    <= '0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i < 11; i++) r_slot[i] <= '0;
    end else if (w_accept) begin
      r_slot[0] <= key_in;
      r_temp    <= key_in;
      r_round   <= 4'd1;
      r_rcon    <= 8'h01;
      busy      <= 1'b1;
      key_valid <= 1'b0;
    end else if (w_wait) begin
      r_slot[r_round] <= exp_key;
      r_temp          <= exp_key;
      if (w_last) begin
        busy      <= 1'b0;
        key_valid <= 1'b1;
      end else begin
        r_round <= r_round + 4'd1;
        r_rcon  <= f_xtime(r_rcon);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= '0;
      rd_err <= 1'b0;
    end else if (rd_round <= 4'd10) begin
      rd_key <= r_slot[rd_round];
      rd_err <= 1'b0;
    end else begin
      rd_key <= '0;
      rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl with a behavioural one-round
// AES-128 expander answering on the cycle after each request.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [0:127] key_in;
  logic [0:127] exp_temp_key;
  logic [0:31]  exp_rcon;
  logic [0:127] exp_key;
  logic         busy;
  logic         key_valid;
  logic [3:0]   rd_round;
  logic [0:127] rd_key;
  logic         rd_err;

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_in       (key_in),
    .exp_temp_key (exp_temp_key),
    .exp_rcon     (exp_rcon),
    .exp_key      (exp_key),
    .busy         (busy),
    .key_valid    (key_valid),
    .rd_round     (rd_round),
    .rd_key       (rd_key),
    .rd_err       (rd_err)
  );

  logic [0:2047] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [0:79] rc_tab = 80'h01020408102040801b36;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_bits[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k,
                                          input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
    t = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always @(posedge clk) exp_key <= expand(exp_temp_key, exp_rcon[0:7]);

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = -1000;
  bit run_active = 1'b0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic         err;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  rd_exp_t rd_e;
  int      lat_q[$];
  bit      rd_issue = 1'b0;
  bit      rd_pend = 1'b0;
  logic    kv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_pend <= rd_issue;

  function void chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endfunction

  function void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [31:0] rcon_exp(int k);
    if (k < 0 || k >= 20) return 32'h0;
    return {rc_tab[(k / 2) * 8 +: 8], 24'h0};
  endfunction

  // Monitor: read returns, key_valid latency and the rcon stream.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        fail("rd_unexpected");
      end else begin
        rd_e = rd_q.pop_front();
        chk({rd_e.name, "_key"}, rd_key, rd_e.key);
        chk({rd_e.name, "_err"}, 128'(rd_err), 128'(rd_e.err));
      end
    end
    if (key_valid === 1'b1 && kv_prev !== 1'b1) begin
      if (lat_q.size() == 0) fail("kv_unexpected_rise");
      else chk("latency", 128'(cyc - start_cyc), 128'(lat_q.pop_front()));
    end
    kv_prev = key_valid;
    if (run_active) chk("exp_rcon", exp_rcon, rcon_exp(cyc - start_cyc));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key_in = k;
    start = 1'b1;
    start_cyc = cyc + 1;
    lat_q.push_back(20);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && key_valid !== 1'b1; i++) tick();
    if (key_valid !== 1'b1) fail({name, "_timeout"});
  endtask

  task automatic wait_k(input int n);
    for (int i = 0; i < 40 && (cyc - start_cyc) < n; i++) tick();
  endtask

  task automatic rd(input int idx, input logic [127:0] k,
                    input logic e, input string name);
    rd_exp_t x;
    x.name = name;
    x.key = k;
    x.err = e;
    rd_round = 4'(idx);
    rd_issue = 1'b1;
    rd_q.push_back(x);
    tick();
  endtask

  task automatic rd_stop;
    rd_issue = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    rd_round = '0;
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_kv", 128'(key_valid), 128'h0);
    chk("rst_rdkey", rd_key, 128'h0);
    chk("rst_rderr", 128'(rd_err), 128'h0);
    rst = 1'b0;
    run_active = 1'b1;
    rd(0, 128'h0, 1'b0, "rst_slot0");
    rd(10, 128'h0, 1'b0, "rst_slot10");
    rd_stop();

    do_start(K1);
    chk("run_busy", 128'(busy), 128'h1);
    chk("run_kv", 128'(key_valid), 128'h0);
    wait_valid("k1");
    chk("done_busy", 128'(busy), 128'h0);
    for (int i = 10; i >= 0; i--)
      rd(i, fips[i], 1'b0, $sformatf("fips%0d", i));
    rd(11, 128'h0, 1'b1, "oob11");
    rd(15, 128'h0, 1'b1, "oob15");
    rd_stop();

    do_start(K1);
    chk("restart_kv_drop", 128'(key_valid), 128'h0);
    wait_k(9);
    start = 1'b1;
    key_in = K2;
    tick();
    start = 1'b0;
    wait_valid("ignored_start");
    rd(0, fips[0], 1'b0, "ign_slot0");
    rd(5, fips[5], 1'b0, "ign_slot5");
    rd(10, fips[10], 1'b0, "ign_slot10");
    rd_stop();

    do_start(K1);
    wait_k(12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_cyc = -1000;
    void'(lat_q.pop_back());
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_kv", 128'(key_valid), 128'h0);
    tick();
    tick();
    rd(0, 128'h0, 1'b0, "abort_slot0");
    rd(1, 128'h0, 1'b0, "abort_slot1");
    rd(7, 128'h0, 1'b0, "abort_slot7");
    rd(10, 128'h0, 1'b0, "abort_slot10");
    rd_stop();
    do_start(K1);
    wait_valid("after_abort");
    rd(1, fips[1], 1'b0, "re_slot1");
    rd(10, fips[10], 1'b0, "re_slot10");
    rd_stop();

    do_start(K2);
    chk("k2_kv_drop", 128'(key_valid), 128'h0);
    wait_valid("k2");
    rd(0, K2, 1'b0, "k2_slot0");
    rd(10, K2_R10, 1'b0, "k2_slot10");
    rd_stop();

    tick();
    if (lat_q.size() != 0) fail("latency_pending");
    if (rd_q.size() != 0) fail("reads_pending");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
